// File: rtl/fwrisc_decode_pc_if.sv
// Decode-stage bus: fetch handoff, register-file read port, execute handshake and PC result.
// master is the decode side; slave is the surrounding fetch/regfile/execute side.
interface fwrisc_decode_pc_if;
   logic        fetch_valid;
   logic [31:0] instr;
   logic        instr_c;
   logic        decode_complete;
   logic [31:0] next_pc;
   logic        next_pc_seq;
   logic [4:0]  rs1_raddr;
   logic [4:0]  rs2_raddr;
   logic [31:0] rs1_rdata;
   logic [31:0] rs2_rdata;
   logic        exec_valid;
   logic        exec_ready;
   logic [31:0] exec_pc;
   logic [31:0] exec_instr;
   logic        exec_c;
   logic [4:0]  exec_rd;
   logic [31:0] exec_op_a;
   logic [31:0] exec_op_b;
   logic [31:0] exec_rs2;
   logic [31:0] exec_imm;
   logic        exec_done;
   logic        exec_branch;
   logic [31:0] exec_target;

   modport master (
      input  fetch_valid, instr, instr_c, rs1_rdata, rs2_rdata, exec_ready, exec_done,
             exec_branch, exec_target,
      output decode_complete, next_pc, next_pc_seq, rs1_raddr, rs2_raddr, exec_valid, exec_pc,
             exec_instr, exec_c, exec_rd, exec_op_a, exec_op_b, exec_rs2, exec_imm
   );

   modport slave (
      output fetch_valid, instr, instr_c, rs1_rdata, rs2_rdata, exec_ready, exec_done,
             exec_branch, exec_target,
      input  decode_complete, next_pc, next_pc_seq, rs1_raddr, rs2_raddr, exec_valid, exec_pc,
             exec_instr, exec_c, exec_rd, exec_op_a, exec_op_b, exec_rs2, exec_imm
   );
endinterface

// File: rtl/fwrisc_decode_pc.sv
// fwrisc decode stage: latches a fetched instruction, reads the register file, issues one
// operand bundle to execute and owns the program counter.
module fwrisc_decode_pc #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic                 clock,
   input logic                 reset,
   fwrisc_decode_pc_if.master  dec_io
);
   typedef enum logic [2:0] {StIdle, StRead, StIssue, StWait, StDone} state_e;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   state_e      state_q, state_d;
   logic [31:0] instr_q;
   logic        instr_c_q;
   logic [31:0] pc_q, pc_d;
   logic        seq_q, seq_d;
   logic [31:0] ex_pc_q, ex_instr_q, op_a_q, op_b_q, rs2_q, imm_q;
   logic [31:0] ex_instr_d, op_a_d, op_b_d, rs2_d, imm_d;
   logic [4:0]  rd_q, rd_d;
   logic        ex_c_q;
   logic        retire;
   logic [31:0] rs1_val, rs2_val;
   logic [6:0]  opcode;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (dec_io.fetch_valid) state_d = StRead;
         StRead:  state_d = StIssue;
         StIssue: if (dec_io.exec_ready) state_d = dec_io.exec_done ? StDone : StWait;
         StWait:  if (dec_io.exec_done) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      dec_io.exec_valid      = (state_q == StIssue);
      dec_io.decode_complete = (state_q == StDone);
      dec_io.next_pc         = pc_q;
      dec_io.next_pc_seq     = seq_q;
      dec_io.rs1_raddr       = instr_q[19:15];
      dec_io.rs2_raddr       = instr_q[24:20];
      dec_io.exec_pc         = ex_pc_q;
      dec_io.exec_instr      = ex_instr_q;
      dec_io.exec_c          = ex_c_q;
      dec_io.exec_rd         = rd_q;
      dec_io.exec_op_a       = op_a_q;
      dec_io.exec_op_b       = op_b_q;
      dec_io.exec_rs2        = rs2_q;
      dec_io.exec_imm        = imm_q;
   end

   // exec_done only counts once the bundle has been accepted (or in the same cycle).
   assign retire = ((state_q == StIssue) && dec_io.exec_ready && dec_io.exec_done) ||
                   ((state_q == StWait) && dec_io.exec_done);

   assign pc_d  = dec_io.exec_branch ? (dec_io.exec_target & ~32'h1)
                                     : (pc_q + (instr_c_q ? 32'd2 : 32'd4));
   assign seq_d = ~dec_io.exec_branch;

   assign opcode  = instr_q[6:0];
   assign rs1_val = (instr_q[19:15] == 5'd0) ? 32'd0 : dec_io.rs1_rdata;
   assign rs2_val = (instr_q[24:20] == 5'd0) ? 32'd0 : dec_io.rs2_rdata;

   // Bundle formed from the latched instruction while in READ
   always_comb begin
      imm_d = 32'd0;
      case (opcode)
         OpImm, OpLoad, OpJalr: imm_d = {{20{instr_q[31]}}, instr_q[31:20]};
         OpStore:  imm_d = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         OpBranch: imm_d = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                            instr_q[11:8], 1'b0};
         OpLui, OpAuipc: imm_d = {instr_q[31:12], 12'd0};
         OpJal:    imm_d = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                            instr_q[30:21], 1'b0};
         default:  imm_d = 32'd0;
      endcase

      if (opcode == OpLui)                          op_a_d = 32'd0;
      else if (opcode == OpAuipc || opcode == OpJal) op_a_d = pc_q;
      else                                           op_a_d = rs1_val;

      op_b_d     = (opcode == OpReg || opcode == OpBranch) ? rs2_val : imm_d;
      rs2_d      = rs2_val;
      rd_d       = instr_q[11:7];
      ex_instr_d = instr_q;

      // Compressed forms are expanded downstream; only the raw halfword travels.
      if (instr_c_q) begin
         imm_d      = 32'd0;
         op_a_d     = 32'd0;
         op_b_d     = 32'd0;
         rs2_d      = 32'd0;
         rd_d       = 5'd0;
         ex_instr_d = {16'd0, instr_q[15:0]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q    <= 32'd0;
         instr_c_q  <= 1'b0;
         pc_q       <= RESET_PC;
         seq_q      <= 1'b1;
         ex_pc_q    <= 32'd0;
         ex_instr_q <= 32'd0;
         ex_c_q     <= 1'b0;
         rd_q       <= 5'd0;
         op_a_q     <= 32'd0;
         op_b_q     <= 32'd0;
         rs2_q      <= 32'd0;
         imm_q      <= 32'd0;
      end else begin
         if ((state_q == StIdle) && dec_io.fetch_valid) begin
            instr_q   <= dec_io.instr;
            instr_c_q <= dec_io.instr_c;
         end
         if (state_q == StRead) begin
            ex_pc_q    <= pc_q;
            ex_instr_q <= ex_instr_d;
            ex_c_q     <= instr_c_q;
            rd_q       <= rd_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
         end
         if (retire) begin
            pc_q  <= pc_d;
            seq_q <= seq_d;
         end
      end
   end
endmodule

// File: tb/tb_fwrisc_decode_pc.sv
// Self-checking bench for fwrisc_decode_pc: hand-derived bundles are queued at fetch and
// compared when the bundle is issued; PC results are checked on each decode_complete.
module tb_fwrisc_decode_pc;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        c;
      logic [4:0]  rd;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] rs2;
      logic [31:0] imm;
   } exp_t;

   logic        clock, reset, sel;
   logic        fetch_valid, instr_c, exec_ready, exec_done, exec_branch;
   logic [31:0] instr, rs1_rdata, rs2_rdata, exec_target;
   logic        o_dc, o_seq, o_valid, o_c;
   logic [31:0] o_npc, o_pc, o_instr, o_a, o_b, o_rs2, o_imm;
   logic [4:0]  o_r1a, o_r2a, o_rd;
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;

   fwrisc_decode_pc_if bus_a ();
   fwrisc_decode_pc_if bus_b ();

   fwrisc_decode_pc u_dut_a (.clock(clock), .reset(reset), .dec_io(bus_a.master));
   fwrisc_decode_pc #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
      .clock(clock), .reset(reset), .dec_io(bus_b.master));

   assign bus_a.fetch_valid = fetch_valid;   assign bus_b.fetch_valid = fetch_valid;
   assign bus_a.instr       = instr;         assign bus_b.instr       = instr;
   assign bus_a.instr_c     = instr_c;       assign bus_b.instr_c     = instr_c;
   assign bus_a.rs1_rdata   = rs1_rdata;     assign bus_b.rs1_rdata   = rs1_rdata;
   assign bus_a.rs2_rdata   = rs2_rdata;     assign bus_b.rs2_rdata   = rs2_rdata;
   assign bus_a.exec_ready  = exec_ready;    assign bus_b.exec_ready  = exec_ready;
   assign bus_a.exec_done   = exec_done;     assign bus_b.exec_done   = exec_done;
   assign bus_a.exec_branch = exec_branch;   assign bus_b.exec_branch = exec_branch;
   assign bus_a.exec_target = exec_target;   assign bus_b.exec_target = exec_target;

   assign o_dc    = sel ? bus_b.decode_complete : bus_a.decode_complete;
   assign o_npc   = sel ? bus_b.next_pc         : bus_a.next_pc;
   assign o_seq   = sel ? bus_b.next_pc_seq     : bus_a.next_pc_seq;
   assign o_r1a   = sel ? bus_b.rs1_raddr       : bus_a.rs1_raddr;
   assign o_r2a   = sel ? bus_b.rs2_raddr       : bus_a.rs2_raddr;
   assign o_valid = sel ? bus_b.exec_valid      : bus_a.exec_valid;
   assign o_pc    = sel ? bus_b.exec_pc         : bus_a.exec_pc;
   assign o_instr = sel ? bus_b.exec_instr      : bus_a.exec_instr;
   assign o_c     = sel ? bus_b.exec_c          : bus_a.exec_c;
   assign o_rd    = sel ? bus_b.exec_rd         : bus_a.exec_rd;
   assign o_a     = sel ? bus_b.exec_op_a       : bus_a.exec_op_a;
   assign o_b     = sel ? bus_b.exec_op_b       : bus_a.exec_op_b;
   assign o_rs2   = sel ? bus_b.exec_rs2        : bus_a.exec_rs2;
   assign o_imm   = sel ? bus_b.exec_imm        : bus_a.exec_imm;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic c,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r2, input logic [31:0] imm);
      exp_t e;
      e.pc = pc; e.instr = ins; e.c = c; e.rd = rd;
      e.op_a = a; e.op_b = b; e.rs2 = r2; e.imm = imm;
      return e;
   endfunction

   task automatic check_bundle(input string tag, input exp_t e);
      check({tag, "_pc"},    o_pc,    e.pc);
      check({tag, "_instr"}, o_instr, e.instr);
      check({tag, "_c"},     {31'd0, o_c},  {31'd0, e.c});
      check({tag, "_rd"},    {27'd0, o_rd}, {27'd0, e.rd});
      check({tag, "_op_a"},  o_a,     e.op_a);
      check({tag, "_op_b"},  o_b,     e.op_b);
      check({tag, "_rs2"},   o_rs2,   e.rs2);
      check({tag, "_imm"},   o_imm,   e.imm);
   endtask

   task automatic do_reset(input logic [31:0] rst_pc);
      fetch_valid = 0; instr = 0; instr_c = 0; rs1_rdata = 0; rs2_rdata = 0;
      exec_ready = 0; exec_done = 0; exec_branch = 0; exec_target = 0;
      reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      check("rst_next_pc", o_npc, rst_pc);
      check("rst_seq",   {31'd0, o_seq},   32'd1);
      check("rst_dc",    {31'd0, o_dc},    32'd0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_raddr", {22'd0, o_r1a, o_r2a}, 32'd0);
      check_bundle("rst", mk(32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0));
   endtask

   // Fetch one instruction, stall issue for `stall` cycles, then complete after `wcyc` WAIT
   // cycles (0 = done with ready); rst_wait aborts it with a reset while in WAIT.
   task automatic run_instr(input logic [31:0] ins, input logic c, input logic [31:0] r1,
                            input logic [31:0] r2, input exp_t e, input int stall,
                            input int wcyc, input logic br, input logic [31:0] tgt,
                            input logic [31:0] exp_npc, input logic exp_seq,
                            input logic rst_wait);
      exp_t got_e;
      int   n;
      logic fast;
      fast = (wcyc == 0) && !rst_wait;
      sb.push_back(e);
      fetch_valid = 1; instr = ins; instr_c = c; rs1_rdata = r1; rs2_rdata = r2;
      @(posedge clock); #1;
      fetch_valid = 0; instr = 32'hFFFF_FFFF; instr_c = ~c;
      @(posedge clock); #1;
      rs1_rdata = $urandom; rs2_rdata = $urandom;
      n = 0;
      while (!o_valid && n < 8) begin
         @(posedge clock); #1;
         n++;
      end
      check("exec_valid", {31'd0, o_valid}, 32'd1);
      got_e = sb.pop_front();
      check_bundle("issue", got_e);
      if (!c) begin
         check("rs1_raddr", {27'd0, o_r1a}, {27'd0, ins[19:15]});
         check("rs2_raddr", {27'd0, o_r2a}, {27'd0, ins[24:20]});
      end
      for (int i = 0; i < stall; i++) begin
         exec_ready = 0;
         @(posedge clock); #1;
         check("stall_valid", {31'd0, o_valid}, 32'd1);
         check_bundle("stall", got_e);
      end
      exec_ready = 1; exec_done = fast; exec_branch = br; exec_target = tgt;
      @(posedge clock); #1;
      exec_ready = 0;
      if (!fast) begin
         for (int i = 0; i < wcyc; i++) begin
            check("wait_dc",    {31'd0, o_dc},    32'd0);
            check("wait_valid", {31'd0, o_valid}, 32'd0);
            @(posedge clock); #1;
         end
         if (rst_wait) begin
            reset = 1; exec_done = 1;
            @(posedge clock); #1;
            reset = 0; exec_done = 0; exec_branch = 0;
            check("rstw_dc",    {31'd0, o_dc},    32'd0);
            check("rstw_npc",   o_npc, exp_npc);
            check("rstw_seq",   {31'd0, o_seq},   32'd1);
            check("rstw_valid", {31'd0, o_valid}, 32'd0);
            @(posedge clock); #1;
            check("rstw_dc2",   {31'd0, o_dc},    32'd0);
            return;
         end
         exec_done = 1;
         @(posedge clock); #1;
      end
      exec_done = 0; exec_branch = 0;
      check("done_dc",  {31'd0, o_dc},  32'd1);
      check("done_npc", o_npc, exp_npc);
      check("done_seq", {31'd0, o_seq}, {31'd0, exp_seq});
      @(posedge clock); #1;
      check("pulse_dc", {31'd0, o_dc}, 32'd0);
      check("hold_npc", o_npc, exp_npc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      sel = 1;
      do_reset(32'hFFFF_FFFC);
      // LUI at the top of the address space: op_a forced to 0, PC wraps to 0
      run_instr(32'h1234_50B7, 0, 32'hAAAA, 32'h5555,
                mk(32'hFFFF_FFFC, 32'h1234_50B7, 0, 5'd1, 32'd0, 32'h1234_5000, 32'h5555,
                   32'h1234_5000), 0, 0, 0, 32'd0, 32'h0000_0000, 1, 0);

      sel = 0;
      do_reset(32'h8000_0000);
      // addi x1,x0,5: x0 reads as zero despite rs1_rdata
      run_instr(32'h0050_0093, 0, 32'hDEAD, 32'h1111,
                mk(32'h8000_0000, 32'h0050_0093, 0, 5'd1, 32'd0, 32'd5, 32'h1111, 32'd5),
                0, 0, 0, 32'd0, 32'h8000_0004, 1, 0);
      // jal x0,+8 taken to an odd target
      run_instr(32'h0080_006F, 0, 32'h3333, 32'h2222,
                mk(32'h8000_0004, 32'h0080_006F, 0, 5'd0, 32'h8000_0004, 32'd8, 32'h2222, 32'd8),
                0, 0, 1, 32'h8000_0009, 32'h8000_0008, 0, 0);
      // add x3,x1,x2 with back-pressure and a late exec_done
      run_instr(32'h0020_81B3, 0, 32'h10, 32'h20,
                mk(32'h8000_0008, 32'h0020_81B3, 0, 5'd3, 32'h10, 32'h20, 32'h20, 32'd0),
                5, 2, 0, 32'd0, 32'h8000_000C, 1, 0);
      // reset while waiting for execute
      run_instr(32'h0050_0093, 0, 32'h1, 32'h1111,
                mk(32'h8000_000C, 32'h0050_0093, 0, 5'd1, 32'd0, 32'd5, 32'h1111, 32'd5),
                1, 2, 1, 32'h4444_0000, 32'h8000_0000, 1, 1);
      // exec_done in IDLE must not move the PC
      exec_done = 1; exec_branch = 1; exec_target = 32'h1234;
      @(posedge clock); #1;
      exec_done = 0; exec_branch = 0;
      check("idle_done_npc", o_npc, 32'h8000_0000);
      check("idle_done_seq", {31'd0, o_seq}, 32'd1);
      check("idle_done_dc",  {31'd0, o_dc},  32'd0);
      // compressed step
      run_instr(32'h0000_0001, 1, 32'hDEAD, 32'hBEEF,
                mk(32'h8000_0000, 32'h0000_0001, 1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0),
                0, 0, 0, 32'd0, 32'h8000_0002, 1, 0);
      // sw x5,-4(x6)
      run_instr(32'hFE53_2E23, 0, 32'h100, 32'h77,
                mk(32'h8000_0002, 32'hFE53_2E23, 0, 5'd28, 32'h100, 32'hFFFF_FFFC, 32'h77,
                   32'hFFFF_FFFC), 0, 1, 0, 32'd0, 32'h8000_0006, 1, 0);
      // beq x1,x2,-8 taken
      run_instr(32'hFE20_8CE3, 0, 32'h5, 32'h6,
                mk(32'h8000_0006, 32'hFE20_8CE3, 0, 5'd25, 32'h5, 32'h6, 32'h6, 32'hFFFF_FFF8),
                2, 0, 1, 32'h7FFF_FFFB, 32'h7FFF_FFFA, 0, 0);
      // auipc x5,1 picks up the redirected PC
      run_instr(32'h0000_1297, 0, 32'h9, 32'h9,
                mk(32'h7FFF_FFFA, 32'h0000_1297, 0, 5'd5, 32'h7FFF_FFFA, 32'h1000, 32'd0,
                   32'h1000), 0, 0, 0, 32'd0, 32'h7FFF_FFFE, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
